// File: rtl/dsp_mac_pipe.sv
// ---------------------------------------------------------------------------
// dsp_mac_pipe
//
// Parametrised multiply-accumulate slice: pre-adder, multiplier and
// post-adder/accumulator in a four-register pipeline with a valid/ready
// handshake. OPMODE is captured with each beat and travels with it, so mode
// changes apply per transaction. The result register P feeds back into the
// post-adder, and PCIN lets several slices be chained.
//
// Optional feature: define DSP_MAC_PIPE_SAT_EN to saturate P on post-adder
// overflow (add) or underflow (sub). Without it P wraps modulo 2^PW.
//
// Parameters:
//   AW - width of operand a
//   BW - width of operands b and d (pre-adder width)
//   PW - width of c, pcin and p; must be greater than AW+BW
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   input beat valid
//   in_ready  out  beat accepted when in_valid & in_ready
//   a         in   multiplier operand (AW)
//   b         in   pre-adder / multiplier operand (BW)
//   d         in   pre-adder operand, low bits also feed the concat (BW)
//   c         in   post-adder Z operand (PW)
//   pcin      in   cascade Z operand (PW)
//   carryin   in   post-adder carry-in
//   opmode    in   per-beat mode, captured with the data (8)
//   out_valid out  p/carryout hold a result
//   out_ready in   downstream accepts the result
//   m         out  stage-3 multiplier register (AW+BW)
//   p         out  result register (PW)
//   carryout  out  post-adder carry (add) or borrow (sub)
// ---------------------------------------------------------------------------
module dsp_mac_pipe #(
   parameter int AW = 18,
   parameter int BW = 18,
   parameter int PW = 48
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AW-1:0]     a,
   input  logic [BW-1:0]     b,
   input  logic [BW-1:0]     d,
   input  logic [PW-1:0]     c,
   input  logic [PW-1:0]     pcin,
   input  logic              carryin,
   input  logic [7:0]        opmode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [AW+BW-1:0]  m,
   output logic [PW-1:0]     p,
   output logic              carryout
);

   localparam int MW = AW + BW;
   localparam int DW = PW - MW;

   // The concat operand {d, a, b} only fits if there is at least one d bit.
   if (PW <= MW) begin : g_param_check
      $error("dsp_mac_pipe: PW must be greater than AW+BW");
   end

   // A single advance enable drives the whole pipeline. Bubbles move
   // along like real beats, so nothing is compressed while stalled.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Stage 1 registers
   logic          s1_v;
   logic [AW-1:0] s1_a;
   logic [BW-1:0] s1_b;
   logic [BW-1:0] s1_d;
   logic [PW-1:0] s1_c;
   logic [PW-1:0] s1_pcin;
   logic          s1_cin;
   logic [7:0]    s1_op;

   // Stage 2 registers
   logic          s2_v;
   logic [AW-1:0] s2_a;
   logic [BW-1:0] s2_b;
   logic [BW-1:0] s2_bp;
   logic [DW-1:0] s2_dlo;
   logic [PW-1:0] s2_c;
   logic [PW-1:0] s2_pcin;
   logic          s2_cin;
   logic [1:0]    s2_xsel;
   logic [1:0]    s2_zsel;
   logic          s2_sub;

   // Stage 3 registers (m is the stage-3 product register)
   logic          s3_v;
   logic [AW-1:0] s3_a;
   logic [BW-1:0] s3_b;
   logic [DW-1:0] s3_dlo;
   logic [PW-1:0] s3_c;
   logic [PW-1:0] s3_pcin;
   logic          s3_cin;
   logic [1:0]    s3_xsel;
   logic [1:0]    s3_zsel;
   logic          s3_sub;

   // Only the low DW bits of d ever reach the concat, so only those are
   // delayed past stage 1. If d is narrower than the slot it is zero-extended.
   logic [DW-1:0] s1_dlo;
   if (DW <= BW) begin : g_dlo_slice
      assign s1_dlo = s1_d[DW-1:0];
   end else begin : g_dlo_ext
      assign s1_dlo = {{(DW-BW){1'b0}}, s1_d};
   end

   // Pre-adder result, wrapping modulo 2^BW.
   logic [BW-1:0] preadd;
   always_comb begin
      preadd = s1_b;
      if (s1_op[4]) begin
         preadd = s1_op[6] ? (s1_d - s1_b) : (s1_d + s1_b);
      end
   end

   // Stage 1: capture the raw input beat along with its mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_d    <= '0;
         s1_c    <= '0;
         s1_pcin <= '0;
         s1_cin  <= 1'b0;
         s1_op   <= '0;
      end else if (adv) begin
         s1_v    <= in_valid;
         s1_a    <= a;
         s1_b    <= b;
         s1_d    <= d;
         s1_c    <= c;
         s1_pcin <= pcin;
         s1_cin  <= carryin;
         s1_op   <= opmode;
      end
   end

   // Stage 2: register the pre-adder output. Only the mode bits the later
   // stages still need are carried on, and carry-in is gated here once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v    <= 1'b0;
         s2_a    <= '0;
         s2_b    <= '0;
         s2_bp   <= '0;
         s2_dlo  <= '0;
         s2_c    <= '0;
         s2_pcin <= '0;
         s2_cin  <= 1'b0;
         s2_xsel <= '0;
         s2_zsel <= '0;
         s2_sub  <= 1'b0;
      end else if (adv) begin
         s2_v    <= s1_v;
         s2_a    <= s1_a;
         s2_b    <= s1_b;
         s2_bp   <= preadd;
         s2_dlo  <= s1_dlo;
         s2_c    <= s1_c;
         s2_pcin <= s1_pcin;
         s2_cin  <= s1_op[5] & s1_cin;
         s2_xsel <= s1_op[1:0];
         s2_zsel <= s1_op[3:2];
         s2_sub  <= s1_op[7];
      end
   end

   // Stage 3: unsigned multiply of a by the pre-adder output. The raw b
   // keeps travelling because the concat uses it rather than the pre-add.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_v    <= 1'b0;
         m       <= '0;
         s3_a    <= '0;
         s3_b    <= '0;
         s3_dlo  <= '0;
         s3_c    <= '0;
         s3_pcin <= '0;
         s3_cin  <= 1'b0;
         s3_xsel <= '0;
         s3_zsel <= '0;
         s3_sub  <= 1'b0;
      end else if (adv) begin
         s3_v    <= s2_v;
         m       <= {{BW{1'b0}}, s2_a} * {{AW{1'b0}}, s2_bp};
         s3_a    <= s2_a;
         s3_b    <= s2_b;
         s3_dlo  <= s2_dlo;
         s3_c    <= s2_c;
         s3_pcin <= s2_pcin;
         s3_cin  <= s2_cin;
         s3_xsel <= s2_xsel;
         s3_zsel <= s2_zsel;
         s3_sub  <= s2_sub;
      end
   end

   // Stage 4 combinational post-adder. Working on PW+1 bits makes the top
   // bit the carry on add and the borrow on subtract. Feedback from p uses
   // the committed register, which is the previous beat's result.
   logic [PW-1:0] x_val;
   logic [PW-1:0] z_val;
   logic [PW:0]   r;
   logic [PW-1:0] p_next;
   always_comb begin
      x_val = '0;
      case (s3_xsel)
         2'd0: x_val = '0;
         2'd1: x_val = {{DW{1'b0}}, m};
         2'd2: x_val = p;
         2'd3: x_val = {s3_dlo, s3_a, s3_b};
         default: x_val = '0;
      endcase

      z_val = '0;
      case (s3_zsel)
         2'd0: z_val = '0;
         2'd1: z_val = s3_pcin;
         2'd2: z_val = p;
         2'd3: z_val = s3_c;
         default: z_val = '0;
      endcase

      if (s3_sub) begin
         r = {1'b0, z_val} - ({1'b0, x_val} + {{PW{1'b0}}, s3_cin});
      end else begin
         r = {1'b0, z_val} + {1'b0, x_val} + {{PW{1'b0}}, s3_cin};
      end

`ifdef DSP_MAC_PIPE_SAT_EN
      // Clamp toward the side the result escaped from.
      if (r[PW]) begin
         p_next = s3_sub ? '0 : '1;
      end else begin
         p_next = r[PW-1:0];
      end
`else
      p_next = r[PW-1:0];
`endif
   end

   // Stage 4: results commit only for real beats; a bubble leaves p and
   // carryout alone but still clears out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         p         <= '0;
         carryout  <= 1'b0;
      end else if (adv) begin
         out_valid <= s3_v;
         if (s3_v) begin
            p        <= p_next;
            carryout <= r[PW];
         end
      end
   end

endmodule
